// File: rtl/otter_pl_id_stage.sv
// OTTER pipelined decode stage.
// Decodes the IF/ID instruction into the ID/EX pipeline register and inserts
// load-use bubbles (LOAD_STALLS per hazard). An EX redirect squashes the
// decode slot. EX-stage operand forwarding selects are also generated here.
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_RUN   | normal flow; a load-use hazard inserts the first bubble here
// ST_STALL | further bubbles for the same hazard; cnt counts the ones left
module otter_pl_id_stage #(
    parameter int XLEN        = 32,
    parameter int RADDR_W     = 5,
    parameter int LOAD_STALLS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_ir,
    input  logic [XLEN-1:0]    id_pc,
    input  logic               ex_redirect,
    input  logic [RADDR_W-1:0] mem_rd,
    input  logic               mem_reg_write,
    input  logic [RADDR_W-1:0] wb_rd,
    input  logic               wb_reg_write,
    output logic               pc_write,
    output logic               ifid_write,
    output logic               ex_valid,
    output logic [XLEN-1:0]    ex_pc,
    output logic [RADDR_W-1:0] ex_rs1,
    output logic [RADDR_W-1:0] ex_rs2,
    output logic [RADDR_W-1:0] ex_rd,
    output logic [2:0]         ex_func3,
    output logic [3:0]         ex_alu_fun,
    output logic               ex_alu_srca,
    output logic [1:0]         ex_alu_srcb,
    output logic [1:0]         ex_rf_wr_sel,
    output logic               ex_reg_write,
    output logic               ex_mem_write,
    output logic               ex_mem_read,
    output logic [1:0]         fwd_a,
    output logic [1:0]         fwd_b
);

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Bubbles still owed after the first one (first bubble is issued from ST_RUN).
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALLS - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    state_t state, next_state;
    logic [2:0] cnt, cnt_next;
    logic       bubble;

    logic [6:0]         opcode;
    logic [2:0]         func3;
    logic               f7_b5;
    logic [RADDR_W-1:0] id_rs1, id_rs2, id_rd;

    logic [3:0] dec_alu_fun;
    logic       dec_alu_srca;
    logic [1:0] dec_alu_srcb;
    logic [1:0] dec_rf_wr_sel;
    logic       dec_wr_en;
    logic       dec_reg_write;
    logic       dec_mem_write;
    logic       dec_mem_read;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       hazard;

    // Only opcode, register fields, func3 and funct7 bit 30 matter to decode.
    logic unused_ir;
    assign unused_ir = ^{id_ir[31], id_ir[29:25]};

    assign opcode = id_ir[6:0];
    assign func3  = id_ir[14:12];
    assign f7_b5  = id_ir[30];
    assign id_rs1 = RADDR_W'(id_ir[19:15]);
    assign id_rs2 = RADDR_W'(id_ir[24:20]);
    assign id_rd  = RADDR_W'(id_ir[11:7]);

    // Instruction decode: datapath selects, enables and source-register usage.
    always_comb begin
        dec_alu_fun   = 4'b0000;
        dec_alu_srca  = 1'b0;
        dec_alu_srcb  = 2'd0;
        dec_rf_wr_sel = 2'd3;
        dec_wr_en     = 1'b0;
        dec_mem_write = 1'b0;
        dec_mem_read  = 1'b0;
        uses_rs1      = 1'b1;
        uses_rs2      = 1'b0;
        case (opcode)
            OP_LUI: begin
                dec_alu_fun  = 4'b1001;
                dec_alu_srca = 1'b1;
                dec_wr_en    = 1'b1;
                uses_rs1     = 1'b0;
            end
            OP_AUIPC: begin
                dec_alu_srca = 1'b1;
                dec_alu_srcb = 2'd3;
                dec_wr_en    = 1'b1;
                uses_rs1     = 1'b0;
            end
            OP_JAL: begin
                dec_rf_wr_sel = 2'd0;
                dec_wr_en     = 1'b1;
                uses_rs1      = 1'b0;
            end
            OP_JALR: begin
                dec_alu_srcb  = 2'd1;
                dec_rf_wr_sel = 2'd0;
                dec_wr_en     = 1'b1;
            end
            OP_BRANCH: begin
                uses_rs2 = 1'b1;
            end
            OP_LOAD: begin
                dec_alu_srcb  = 2'd1;
                dec_rf_wr_sel = 2'd2;
                dec_wr_en     = 1'b1;
                dec_mem_read  = 1'b1;
            end
            OP_STORE: begin
                dec_alu_srcb  = 2'd2;
                dec_mem_write = 1'b1;
                uses_rs2      = 1'b1;
            end
            OP_IMM: begin
                // Only the shift-right group uses funct7 to pick SRLI vs SRAI.
                dec_alu_fun  = (func3 == 3'b101) ? {f7_b5, func3} : {1'b0, func3};
                dec_alu_srcb = 2'd1;
                dec_wr_en    = 1'b1;
            end
            OP_OP: begin
                dec_alu_fun = {f7_b5, func3};
                dec_wr_en   = 1'b1;
                uses_rs2    = 1'b1;
            end
            OP_SYSTEM: begin
                dec_rf_wr_sel = 2'd1;
            end
            default: begin
                dec_alu_fun = 4'b0000;
            end
        endcase
        dec_reg_write = dec_wr_en & (id_rd != '0);
    end

    // Load-use hazard: decoding instruction reads the rd of the load now in EX.
    always_comb begin
        hazard = id_valid & ex_valid & ex_mem_read & (ex_rd != '0) &
                 ((uses_rs1 & (id_rs1 == ex_rd)) | (uses_rs2 & (id_rs2 == ex_rd)));
    end

    // Stall FSM state and bubble counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
            cnt   <= 3'd0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Next-state, bubble request and IF write enables; redirect overrides everything.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        bubble     = 1'b0;
        pc_write   = 1'b1;
        ifid_write = 1'b1;
        if (ex_redirect) begin
            bubble     = 1'b1;
            next_state = ST_RUN;
            cnt_next   = 3'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (hazard) begin
                        pc_write   = 1'b0;
                        ifid_write = 1'b0;
                        bubble     = 1'b1;
                        cnt_next   = STALL_INIT;
                        next_state = (STALL_INIT != 3'd0) ? ST_STALL : ST_RUN;
                    end
                end
                ST_STALL: begin
                    pc_write   = 1'b0;
                    ifid_write = 1'b0;
                    bubble     = 1'b1;
                    cnt_next   = cnt - 3'd1;
                    // cnt <= 1 also recovers from an impossible zero count.
                    if (cnt <= 3'd1) begin
                        next_state = ST_RUN;
                        cnt_next   = 3'd0;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    cnt_next   = 3'd0;
                end
            endcase
        end
    end

    // ID/EX pipeline register; a bubble clears the whole slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_func3     <= 3'd0;
            ex_alu_fun   <= 4'd0;
            ex_alu_srca  <= 1'b0;
            ex_alu_srcb  <= 2'd0;
            ex_rf_wr_sel <= 2'd0;
            ex_reg_write <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else if (bubble) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_rs1       <= '0;
            ex_rs2       <= '0;
            ex_rd        <= '0;
            ex_func3     <= 3'd0;
            ex_alu_fun   <= 4'd0;
            ex_alu_srca  <= 1'b0;
            ex_alu_srcb  <= 2'd0;
            ex_rf_wr_sel <= 2'd0;
            ex_reg_write <= 1'b0;
            ex_mem_write <= 1'b0;
            ex_mem_read  <= 1'b0;
        end else begin
            ex_valid     <= id_valid;
            ex_pc        <= id_pc;
            ex_rs1       <= id_rs1;
            ex_rs2       <= id_rs2;
            ex_rd        <= id_rd;
            ex_func3     <= func3;
            ex_alu_fun   <= dec_alu_fun;
            ex_alu_srca  <= dec_alu_srca;
            ex_alu_srcb  <= dec_alu_srcb;
            ex_rf_wr_sel <= dec_rf_wr_sel;
            ex_reg_write <= dec_reg_write & id_valid;
            ex_mem_write <= dec_mem_write & id_valid;
            ex_mem_read  <= dec_mem_read & id_valid;
        end
    end

    // Forwarding select for one EX source; the younger EX/MEM result wins ties.
    function automatic logic [1:0] fwd_sel(
        input logic [RADDR_W-1:0] rs,
        input logic               valid,
        input logic [RADDR_W-1:0] m_rd,
        input logic               m_wr,
        input logic [RADDR_W-1:0] w_rd,
        input logic               w_wr
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (valid) begin
            if (m_wr && (m_rd != '0) && (m_rd == rs)) begin
                sel = 2'b01;
            end else if (w_wr && (w_rd != '0) && (w_rd == rs)) begin
                sel = 2'b10;
            end
        end
        return sel;
    endfunction

    // EX operand forwarding selects from the registered source fields.
    always_comb begin
        fwd_a = fwd_sel(ex_rs1, ex_valid, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
        fwd_b = fwd_sel(ex_rs2, ex_valid, mem_rd, mem_reg_write, wb_rd, wb_reg_write);
    end

endmodule

// File: tb/tb_otter_pl_id_stage.sv
// Bench for otter_pl_id_stage: two instances (LOAD_STALLS=1 and 3), each
// checked every cycle against a behavioural model plus directed literal checks.
module tb_otter_pl_id_stage;

    logic clk = 1'b0;
    logic rst;

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    logic        id_valid[2];
    logic [31:0] id_ir[2];
    logic [31:0] id_pc[2];
    logic        ex_redirect[2];
    logic [4:0]  mem_rd[2];
    logic        mem_reg_write[2];
    logic [4:0]  wb_rd[2];
    logic        wb_reg_write[2];

    logic        pc_write[2];
    logic        ifid_write[2];
    logic        ex_valid[2];
    logic [31:0] ex_pc[2];
    logic [4:0]  ex_rs1[2];
    logic [4:0]  ex_rs2[2];
    logic [4:0]  ex_rd[2];
    logic [2:0]  ex_func3[2];
    logic [3:0]  ex_alu_fun[2];
    logic        ex_alu_srca[2];
    logic [1:0]  ex_alu_srcb[2];
    logic [1:0]  ex_rf_wr_sel[2];
    logic        ex_reg_write[2];
    logic        ex_mem_write[2];
    logic        ex_mem_read[2];
    logic [1:0]  fwd_a[2];
    logic [1:0]  fwd_b[2];

    int n_assert = 0;
    int n_fail   = 0;

    logic       last_pcw;
    logic [1:0] last_fa;
    logic [1:0] last_fb;

    otter_pl_id_stage #(.XLEN(32), .RADDR_W(5), .LOAD_STALLS(1)) dut1 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[0]), .id_ir(id_ir[0]), .id_pc(id_pc[0]),
        .ex_redirect(ex_redirect[0]),
        .mem_rd(mem_rd[0]), .mem_reg_write(mem_reg_write[0]),
        .wb_rd(wb_rd[0]), .wb_reg_write(wb_reg_write[0]),
        .pc_write(pc_write[0]), .ifid_write(ifid_write[0]),
        .ex_valid(ex_valid[0]), .ex_pc(ex_pc[0]),
        .ex_rs1(ex_rs1[0]), .ex_rs2(ex_rs2[0]), .ex_rd(ex_rd[0]),
        .ex_func3(ex_func3[0]), .ex_alu_fun(ex_alu_fun[0]),
        .ex_alu_srca(ex_alu_srca[0]), .ex_alu_srcb(ex_alu_srcb[0]),
        .ex_rf_wr_sel(ex_rf_wr_sel[0]), .ex_reg_write(ex_reg_write[0]),
        .ex_mem_write(ex_mem_write[0]), .ex_mem_read(ex_mem_read[0]),
        .fwd_a(fwd_a[0]), .fwd_b(fwd_b[0])
    );

    otter_pl_id_stage #(.XLEN(32), .RADDR_W(5), .LOAD_STALLS(3)) dut3 (
        .clk(clk), .rst(rst),
        .id_valid(id_valid[1]), .id_ir(id_ir[1]), .id_pc(id_pc[1]),
        .ex_redirect(ex_redirect[1]),
        .mem_rd(mem_rd[1]), .mem_reg_write(mem_reg_write[1]),
        .wb_rd(wb_rd[1]), .wb_reg_write(wb_reg_write[1]),
        .pc_write(pc_write[1]), .ifid_write(ifid_write[1]),
        .ex_valid(ex_valid[1]), .ex_pc(ex_pc[1]),
        .ex_rs1(ex_rs1[1]), .ex_rs2(ex_rs2[1]), .ex_rd(ex_rd[1]),
        .ex_func3(ex_func3[1]), .ex_alu_fun(ex_alu_fun[1]),
        .ex_alu_srca(ex_alu_srca[1]), .ex_alu_srcb(ex_alu_srcb[1]),
        .ex_rf_wr_sel(ex_rf_wr_sel[1]), .ex_reg_write(ex_reg_write[1]),
        .ex_mem_write(ex_mem_write[1]), .ex_mem_read(ex_mem_read[1]),
        .fwd_a(fwd_a[1]), .fwd_b(fwd_b[1])
    );

    task automatic chkw(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, i, act, exp);
        end
    endtask

    task automatic chk1(input string name, input int i, input logic act, input logic exp);
        chkw(name, i, 32'(act), 32'(exp));
    endtask

    // Architectural meaning of each opcode, as the decode tables define it.
    typedef struct packed {
        logic [3:0] alu;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] sel;
        logic       rw;
        logic       mw;
        logic       mr;
        logic       u1;
        logic       u2;
    } dec_t;

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [3:0]  alu;
        logic        srca;
        logic [1:0]  srcb;
        logic [1:0]  sel;
        logic        rw;
        logic        mw;
        logic        mr;
    } exreg_t;

    function automatic dec_t decode(input logic [31:0] ir);
        dec_t d;
        d     = '0;
        d.sel = 2'd3;
        d.u1  = 1'b1;
        case (ir[6:0])
            7'b0110111: begin d.alu = 4'b1001; d.srca = 1'b1; d.rw = 1'b1; d.u1 = 1'b0; end
            7'b0010111: begin d.srca = 1'b1; d.srcb = 2'd3; d.rw = 1'b1; d.u1 = 1'b0; end
            7'b1101111: begin d.sel = 2'd0; d.rw = 1'b1; d.u1 = 1'b0; end
            7'b1100111: begin d.srcb = 2'd1; d.sel = 2'd0; d.rw = 1'b1; end
            7'b1100011: begin d.u2 = 1'b1; end
            7'b0000011: begin d.srcb = 2'd1; d.sel = 2'd2; d.rw = 1'b1; d.mr = 1'b1; end
            7'b0100011: begin d.srcb = 2'd2; d.mw = 1'b1; d.u2 = 1'b1; end
            7'b0010011: begin
                d.alu  = (ir[14:12] == 3'b101) ? {ir[30], ir[14:12]} : {1'b0, ir[14:12]};
                d.srcb = 2'd1;
                d.rw   = 1'b1;
            end
            7'b0110011: begin d.alu = {ir[30], ir[14:12]}; d.rw = 1'b1; d.u2 = 1'b1; end
            7'b1110011: begin d.sel = 2'd1; end
            default:    begin d.u1 = 1'b1; end
        endcase
        if (ir[11:7] == 5'd0) d.rw = 1'b0;
        return d;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : mdl
        localparam int STALLS = (g == 0) ? 1 : 3;
        exreg_t m;
        int     stall_left;

        function automatic logic haz();
            dec_t d;
            d = decode(id_ir[g]);
            return id_valid[g] && m.v && m.mr && (m.rd != 5'd0) &&
                   ((d.u1 && id_ir[g][19:15] == m.rd) || (d.u2 && id_ir[g][24:20] == m.rd));
        endfunction

        function automatic logic exp_pcw();
            return ex_redirect[g] || (stall_left == 0 && !haz());
        endfunction

        function automatic logic [1:0] exp_fwd(input logic [4:0] rs);
            if (!m.v) return 2'b00;
            if (mem_reg_write[g] && mem_rd[g] != 5'd0 && mem_rd[g] == rs) return 2'b01;
            if (wb_reg_write[g] && wb_rd[g] != 5'd0 && wb_rd[g] == rs) return 2'b10;
            return 2'b00;
        endfunction

        function automatic exreg_t nxt_load();
            exreg_t r;
            dec_t   d;
            d      = decode(id_ir[g]);
            r.v    = id_valid[g];
            r.pc   = id_pc[g];
            r.rs1  = id_ir[g][19:15];
            r.rs2  = id_ir[g][24:20];
            r.rd   = id_ir[g][11:7];
            r.f3   = id_ir[g][14:12];
            r.alu  = d.alu;
            r.srca = d.srca;
            r.srcb = d.srcb;
            r.sel  = d.sel;
            r.rw   = d.rw & id_valid[g];
            r.mw   = d.mw & id_valid[g];
            r.mr   = d.mr & id_valid[g];
            return r;
        endfunction

        // Model: a hazard costs STALLS bubbles in total; redirect always wins.
        always @(posedge clk or posedge rst) begin
            if (rst) begin
                m <= '0;
                stall_left <= 0;
            end else if (ex_redirect[g]) begin
                m <= '0;
                stall_left <= 0;
            end else if (stall_left > 0) begin
                m <= '0;
                stall_left <= stall_left - 1;
            end else if (haz()) begin
                m <= '0;
                stall_left <= STALLS - 1;
            end else begin
                m <= nxt_load();
            end
        end

        // Per-cycle comparison against the model.
        always @(negedge clk) begin
            if (!rst) begin
                chk1("pc_write", g, pc_write[g], exp_pcw());
                chk1("ifid_write", g, ifid_write[g], exp_pcw());
                chk1("ex_valid", g, ex_valid[g], m.v);
                chk1("ex_reg_write", g, ex_reg_write[g], m.rw);
                chk1("ex_mem_write", g, ex_mem_write[g], m.mw);
                chk1("ex_mem_read", g, ex_mem_read[g], m.mr);
                chkw("fwd_a", g, 32'(fwd_a[g]), 32'(exp_fwd(m.rs1)));
                chkw("fwd_b", g, 32'(fwd_b[g]), 32'(exp_fwd(m.rs2)));
                if (m.v) begin
                    chkw("ex_pc", g, ex_pc[g], m.pc);
                    chkw("ex_rs1", g, 32'(ex_rs1[g]), 32'(m.rs1));
                    chkw("ex_rs2", g, 32'(ex_rs2[g]), 32'(m.rs2));
                    chkw("ex_rd", g, 32'(ex_rd[g]), 32'(m.rd));
                    chkw("ex_func3", g, 32'(ex_func3[g]), 32'(m.f3));
                    chkw("ex_alu_fun", g, 32'(ex_alu_fun[g]), 32'(m.alu));
                    chk1("ex_alu_srca", g, ex_alu_srca[g], m.srca);
                    chkw("ex_alu_srcb", g, 32'(ex_alu_srcb[g]), 32'(m.srcb));
                    chkw("ex_rf_wr_sel", g, 32'(ex_rf_wr_sel[g]), 32'(m.sel));
                end
            end
        end
    end

    // Apply one cycle of ID/EX-side inputs, record comb outputs, then clock.
    task automatic step(input int i, input logic v, input logic [31:0] ir, input logic [31:0] pc,
                        input logic redir, input logic [4:0] mrd, input logic mw,
                        input logic [4:0] wrd, input logic ww);
        id_valid[i]      = v;
        id_ir[i]         = ir;
        id_pc[i]         = pc;
        ex_redirect[i]   = redir;
        mem_rd[i]        = mrd;
        mem_reg_write[i] = mw;
        wb_rd[i]         = wrd;
        wb_reg_write[i]  = ww;
        #1;
        last_pcw = pc_write[i];
        last_fa  = fwd_a[i];
        last_fb  = fwd_b[i];
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int i);
        step(i, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    logic [31:0] lw5, lw0, add6, add6_x0, add5, sub7, addi8, addi9;
    int lows;

    initial begin
        lw5     = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
        lw0     = {12'd0, 5'd1, 3'b010, 5'd0, 7'b0000011};
        add6    = {7'd0, 5'd2, 5'd5, 3'b000, 5'd6, 7'b0110011};
        add6_x0 = {7'd0, 5'd2, 5'd0, 3'b000, 5'd6, 7'b0110011};
        add5    = {7'd0, 5'd2, 5'd1, 3'b000, 5'd5, 7'b0110011};
        sub7    = {7'b0100000, 5'd5, 5'd5, 3'b000, 5'd7, 7'b0110011};
        addi8   = {12'd1, 5'd6, 3'b000, 5'd8, 7'b0010011};
        addi9   = {12'd5, 5'd0, 3'b000, 5'd9, 7'b0010011};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            id_valid[i] = 1'b0; id_ir[i] = 32'h0; id_pc[i] = 32'h0; ex_redirect[i] = 1'b0;
            mem_rd[i] = 5'd0; mem_reg_write[i] = 1'b0; wb_rd[i] = 5'd0; wb_reg_write[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk1("reset_pc_write", i, pc_write[i], 1'b1);
            chk1("reset_ifid_write", i, ifid_write[i], 1'b1);
            chk1("reset_ex_valid", i, ex_valid[i], 1'b0);
            chk1("reset_ex_reg_write", i, ex_reg_write[i], 1'b0);
            chkw("reset_fwd_a", i, 32'(fwd_a[i]), 32'd0);
        end
        rst = 1'b0;

        // lw x5 / add x6,x5,x2 with one bubble, then MEM/WB forwarding.
        step(0, 1'b1, lw5, 32'h100, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("A_lw_mem_read", 0, ex_mem_read[0], 1'b1);
        chkw("A_lw_rd", 0, 32'(ex_rd[0]), 32'd5);
        step(0, 1'b1, add6, 32'h104, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("A_stall_pcw", 0, last_pcw, 1'b0);
        chk1("A_bubble", 0, ex_valid[0], 1'b0);
        step(0, 1'b1, add6, 32'h104, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        chk1("A_resume_pcw", 0, last_pcw, 1'b1);
        chk1("A_add_valid", 0, ex_valid[0], 1'b1);
        chkw("A_add_pc", 0, ex_pc[0], 32'h104);
        step(0, 1'b1, addi8, 32'h108, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        chkw("A_fwd_a_wb", 0, 32'(last_fa), 32'd2);
        chkw("A_fwd_b_rf", 0, 32'(last_fb), 32'd0);
        chkw("A_addi_alu_srcb", 0, 32'(ex_alu_srcb[0]), 32'd1);
        idle(0);

        // Same pair with three bubbles.
        step(1, 1'b1, lw5, 32'h200, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        lows = 0;
        for (int k = 0; k < 10; k++) begin
            step(1, 1'b1, add6, 32'h204, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
            if (last_pcw) break;
            lows++;
        end
        chkw("B_stall_cycles", 1, 32'(lows), 32'd3);
        chk1("B_add_valid", 1, ex_valid[1], 1'b1);
        chkw("B_add_rd", 1, 32'(ex_rd[1]), 32'd6);
        idle(1);

        // Load to x0 never stalls and never writes.
        step(0, 1'b1, lw0, 32'h300, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("C_lw0_reg_write", 0, ex_reg_write[0], 1'b0);
        chk1("C_lw0_mem_read", 0, ex_mem_read[0], 1'b1);
        step(0, 1'b1, add6_x0, 32'h304, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("C_no_stall", 0, last_pcw, 1'b1);
        chk1("C_add_valid", 0, ex_valid[0], 1'b1);
        step(0, 1'b0, lw5, 32'h308, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("C_invalid_mem_read", 0, ex_mem_read[0], 1'b0);
        idle(0);

        // EX/MEM beats MEM/WB on both operands.
        step(0, 1'b1, add5, 32'h400, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(0, 1'b1, sub7, 32'h404, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chkw("D_sub_alu_fun", 0, 32'(ex_alu_fun[0]), 32'h8);
        step(0, 1'b0, 32'h0, 32'h0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1);
        chkw("D_fwd_a_mem", 0, 32'(last_fa), 32'd1);
        chkw("D_fwd_b_mem", 0, 32'(last_fb), 32'd1);
        idle(0);

        // Hazard coinciding with redirect: squash, no stall.
        step(0, 1'b1, lw5, 32'h500, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(0, 1'b1, add6, 32'h504, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("E_redirect_pcw", 0, last_pcw, 1'b1);
        chk1("E_squash", 0, ex_valid[0], 1'b0);
        step(0, 1'b1, addi9, 32'h800, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("E_target_pcw", 0, last_pcw, 1'b1);
        chk1("E_target_valid", 0, ex_valid[0], 1'b1);
        idle(0);

        // Reset during the stall (cnt=2) leaves no residual bubbles.
        step(1, 1'b1, lw5, 32'h600, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1, 1'b1, add6, 32'h604, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("F_stalled", 1, pc_write[1], 1'b0);
        rst = 1'b1;
        #1;
        chk1("F_rst_pcw_async", 1, pc_write[1], 1'b1);
        @(posedge clk);
        #1;
        chk1("F_rst_pcw", 1, pc_write[1], 1'b1);
        chk1("F_rst_ex_valid", 1, ex_valid[1], 1'b0);
        rst = 1'b0;
        step(1, 1'b1, add6, 32'h604, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("F_no_residual", 1, last_pcw, 1'b1);
        chk1("F_add_valid", 1, ex_valid[1], 1'b1);
        idle(1);

        // Redirect while in the stall state ends the stall at once.
        step(1, 1'b1, lw5, 32'h700, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1, 1'b1, add6, 32'h704, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step(1, 1'b1, add6, 32'h704, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("G_redirect_pcw", 1, last_pcw, 1'b1);
        chk1("G_squash", 1, ex_valid[1], 1'b0);
        step(1, 1'b1, addi9, 32'h900, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        chk1("G_target_pcw", 1, last_pcw, 1'b1);
        chk1("G_target_valid", 1, ex_valid[1], 1'b1);
        idle(1);
        idle(0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
